controle_contador: RTL and testbench

Sequencing controller for the time-selection counter datapath. It latches the counter preset from the V/Q mode inputs and drives the counter's load, clear and count permissions. It divides the system clock into count ticks and handles pause, restart and terminal-count detection. It sits between the front-panel inputs and the external down-counter, which reports `count_zero` back.

---
 rtl/controle_contador.sv | 121 ++++++++++++
 tb/tb_controle_contador.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_contador.sv
// rtl/controle_contador.sv - sequencing controller for the time-selection down-counter
// Latches the mode preset, divides clk into count ticks, and steers the counter's load/clear/count controls.
module controle_contador #(
    parameter int TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       V,
    input  logic       Q,
    input  logic       start,
    input  logic       pause_n,
    input  logic       restart_n,
    input  logic       count_zero,
    output logic [4:0] S,
    output logic       load_permission,
    output logic       clear_permission,
    output logic       count_permission,
    output logic       done,
    output logic [2:0] estado
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        COUNT  = 3'd2,
        PAUSED = 3'd3,
        DONE   = 3'd4,
        CLEAR  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [4:0]    s_q;
    logic          load_q, clear_n_q, done_q;
    logic [4:0]    preset;
    logic          preset_valid;
    logic          latch_s;

    always_comb begin
        preset = 5'd0;
        case ({V, Q})
            2'b01:   preset = 5'd14;
            2'b10:   preset = 5'd24;
            default: preset = 5'd0;
        endcase
    end

    assign preset_valid = (preset != 5'd0);

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        latch_s = 1'b0;
        if (!restart_n) begin
            state_d = CLEAR;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start && preset_valid) begin
                        state_d = LOAD;
                        latch_s = 1'b1;
                    end
                end
                LOAD: begin
                    state_d = COUNT;
                    presc_d = '0;
                end
                COUNT: begin
                    if (count_zero) begin
                        state_d = DONE;
                    end else if (!pause_n) begin
                        state_d = PAUSED;
                    end
                end
                PAUSED: begin
                    if (pause_n) begin
                        state_d = COUNT;
                    end
                end
                CLEAR:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        // The release cycle out of PAUSED also advances the prescaler, so only paused cycles are skipped.
        if ((state_q == COUNT || state_q == PAUSED) && pause_n && restart_n) begin
            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            s_q       <= 5'd0;
            load_q    <= 1'b0;
            clear_n_q <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            if (latch_s) begin
                s_q <= preset;
            end
            load_q    <= (state_d == LOAD);
            clear_n_q <= (state_d != CLEAR);
            done_q    <= (state_d == DONE);
        end
    end

    assign S                = s_q;
    assign load_permission  = load_q;
    assign clear_permission = clear_n_q;
    assign done             = done_q;
    assign estado           = state_q;
    assign count_permission = (state_q == COUNT) && (presc_q == PRESC_LAST) && pause_n
                              && restart_n && !count_zero;

endmodule

// File: tb/tb_controle_contador.sv
// tb/tb_controle_contador.sv - self-checking bench for controle_contador
// Models the external down-counter and scoreboards expected count-pulse cycles.
module tb_controle_contador;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       V, Q, start, pause_n, restart_n, cz_force;
    logic       count_zero;
    logic [4:0] S;
    logic       load_permission, clear_permission, count_permission, done;
    logic [2:0] estado;
    logic [4:0] cnt;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         exp_q[$];
    logic [4:0] last_s;

    controle_contador #(.TICK_DIV(TD)) dut (
        .clk(clk), .reset(reset), .V(V), .Q(Q), .start(start),
        .pause_n(pause_n), .restart_n(restart_n), .count_zero(count_zero),
        .S(S), .load_permission(load_permission), .clear_permission(clear_permission),
        .count_permission(count_permission), .done(done), .estado(estado)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge reset) begin
        if (reset)                            cnt <= 5'd0;
        else if (!clear_permission)           cnt <= 5'd0;
        else if (load_permission)             cnt <= S;
        else if (count_permission && cnt != 0) cnt <= cnt - 5'd1;
    end

    assign count_zero = (cnt == 5'd0) | cz_force;

    task automatic test_reset();
        reset = 1'b1; V = 1'b0; Q = 1'b0; start = 1'b0;
        pause_n = 1'b1; restart_n = 1'b1; cz_force = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({estado, S, load_permission, clear_permission, count_permission, done} !== {3'd0, 5'd0, 4'b0100}) begin
            errors++;
            $display("FAIL reset_values got estado=%0d S=%0d ld=%b clr=%b cp=%b dn=%b want 0 0 0 1 0 0",
                     estado, S, load_permission, clear_permission, count_permission, done);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (estado !== 3'd0 || clear_permission !== 1'b1 || load_permission !== 1'b0) begin
            errors++;
            $display("FAIL after_reset got estado=%0d clr=%b ld=%b want 0 1 0", estado, clear_permission, load_permission);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_count_mode(input logic v, input logic q, input logic [4:0] exp_s);
        int  l_cyc, done_cyc, done_at, loads, got, n;
        bit  seen_done;
        n = int'(exp_s);
        exp_q.delete();
        V = v; Q = q; start = 1'b1;
        l_cyc = cyc + 1;
        for (int i = 0; i < n; i++) exp_q.push_back(l_cyc + TD + TD * i);
        done_cyc = l_cyc + TD + TD * (n - 1) + 2;
        last_s = exp_s;
        @(posedge clk); #1;
        start = 1'b0;
        loads = 0; seen_done = 0; done_at = -1;
        for (int b = 0; b < 400 && !seen_done; b++) begin
            @(negedge clk);
            if (load_permission) begin
                loads++;
                checks++;
                if (cyc !== l_cyc || S !== exp_s) begin
                    errors++;
                    $display("FAIL load_pulse got cyc=%0d S=%0d want cyc=%0d S=%0d", cyc, S, l_cyc, exp_s);
                end
            end
            if (count_permission) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_pulse got pulse at cyc=%0d want none", cyc);
                end else begin
                    got = exp_q.pop_front();
                    if (cyc !== got) begin
                        errors++;
                        $display("FAIL pulse_time got cyc=%0d want cyc=%0d", cyc, got);
                    end
                end
            end
            if (done) begin
                seen_done = 1;
                done_at = cyc;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (!seen_done || done_at != done_cyc) begin
            errors++;
            $display("FAIL done_time got cyc=%0d want cyc=%0d", done_at, done_cyc);
        end
        checks++;
        if (exp_q.size() != 0 || loads != 1) begin
            errors++;
            $display("FAIL pulse_count got missing=%0d loads=%0d want 0 1", exp_q.size(), loads);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (count_permission !== 1'b0 || done !== 1'b1 || estado !== 3'd4) begin
                errors++;
                $display("FAIL hold_done got cp=%b done=%b estado=%0d want 0 1 4", count_permission, done, estado);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_pause();
        int  p, got;
        bit  found;
        V = 1'b1; Q = 1'b0; start = 1'b1;
        last_s = 5'd24;
        @(posedge clk); #1;
        start = 1'b0;
        found = 0; p = -1;
        for (int b = 0; b < 20 && !found; b++) begin
            @(negedge clk);
            if (count_permission) begin found = 1; p = cyc; end
            @(posedge clk); #1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL pause_first_pulse got none want pulse within 20 cycles");
        end
        exp_q.delete();
        exp_q.push_back(p + 14);
        while (cyc <= p + 15) begin
            pause_n = !(cyc >= p + 2 && cyc <= p + 11);
            @(negedge clk);
            if (count_permission) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pause_extra_pulse got pulse at cyc=%0d want none", cyc);
                end else begin
                    got = exp_q.pop_front();
                    if (cyc !== got) begin
                        errors++;
                        $display("FAIL pause_pulse_time got cyc=%0d want cyc=%0d", cyc, got);
                    end
                end
            end
            if (cyc == p + 5) begin
                checks++;
                if (estado !== 3'd3) begin
                    errors++;
                    $display("FAIL pause_state got estado=%0d want 3", estado);
                end
            end
            @(posedge clk); #1;
        end
        pause_n = 1'b1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pause_resume got missing=%0d want 0", exp_q.size());
        end
    endtask

    task automatic test_restart_priority();
        bit found;
        found = 0;
        for (int b = 0; b < 10 && !found; b++) begin
            @(negedge clk);
            if (count_permission) found = 1;
            @(posedge clk); #1;
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (count_permission !== 1'b0 || estado !== 3'd2) begin
                errors++;
                $display("FAIL pre_restart got cp=%b estado=%0d want 0 2", count_permission, estado);
            end
            @(posedge clk); #1;
        end
        restart_n = 1'b0; pause_n = 1'b0; cz_force = 1'b1;
        @(negedge clk);
        checks++;
        if (count_permission !== 1'b0 || !found) begin
            errors++;
            $display("FAIL restart_suppress got cp=%b found=%0d want 0 1", count_permission, found);
        end
        @(posedge clk); #1;
        restart_n = 1'b1; pause_n = 1'b1; cz_force = 1'b0;
        @(negedge clk);
        checks++;
        if (estado !== 3'd5 || clear_permission !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL clear_state got estado=%0d clr=%b done=%b want 5 0 0", estado, clear_permission, done);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (estado !== 3'd0 || clear_permission !== 1'b1 || done !== 1'b0 || load_permission !== 1'b0) begin
            errors++;
            $display("FAIL after_clear got estado=%0d clr=%b done=%b ld=%b want 0 1 0 0",
                     estado, clear_permission, done, load_permission);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_invalid_modes();
        logic [1:0] pats [2];
        pats[0] = 2'b00;
        pats[1] = 2'b11;
        for (int i = 0; i < 2; i++) begin
            {V, Q} = pats[i];
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                checks++;
                if (estado !== 3'd0 || load_permission !== 1'b0 || S !== last_s) begin
                    errors++;
                    $display("FAIL invalid_mode_%0d got estado=%0d ld=%b S=%0d want 0 0 %0d",
                             i, estado, load_permission, S, last_s);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset_mid();
        V = 1'b0; Q = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        checks++;
        if (estado !== 3'd2 || S !== 5'd14) begin
            errors++;
            $display("FAIL pre_reset got estado=%0d S=%0d want 2 14", estado, S);
        end
        reset = 1'b1;
        #2;
        checks++;
        if ({estado, S, load_permission, clear_permission, count_permission, done} !== {3'd0, 5'd0, 4'b0100}) begin
            errors++;
            $display("FAIL async_reset got estado=%0d S=%0d ld=%b clr=%b cp=%b dn=%b want 0 0 0 1 0 0",
                     estado, S, load_permission, clear_permission, count_permission, done);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (estado !== 3'd0 || load_permission !== 1'b0 || clear_permission !== 1'b1) begin
            errors++;
            $display("FAIL post_reset got estado=%0d ld=%b clr=%b want 0 0 1", estado, load_permission, clear_permission);
        end
    endtask

    initial begin
        test_reset();
        test_count_mode(1'b0, 1'b1, 5'd14);
        test_count_mode(1'b1, 1'b0, 5'd24);
        test_count_mode(1'b0, 1'b1, 5'd14);
        test_pause();
        test_restart_priority();
        test_invalid_modes();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
